led_panel_driver: RTL
=====================

# led_panel_driver

Scan driver that generates the LED board signals R1, A, clk and lat from an internal double-buffered 2-row pixel store. It replaces hand-driven pin inputs with a free-running sequencer. It sits between the FPGA core, which writes rows and requests buffer swaps, and the JA Pmod header connected to the LED board. It is the transmitting end of the same shift/latch/address protocol the board consumes.

## Interface
- COLS, 32, pixels per row; the number of bits shifted per row (≥2).
- CLK_DIV, 2, system cycles per shift-clock phase (≥1).
- HOLD_CYCLES, 64, post-latch display dwell in system cycles; used only with ROW_HOLD_EN (≥1).

- clkin  input  1  system clock; all logic on rising edge.
- rstin  input  1  synchronous reset, active-high.
- wr_en  input  1  write one row into the back buffer this cycle.
- wr_row  input  1  row index for the write (0 or 1).
- wr_data  input  COLS  row pixels; bit COLS-1 is shifted out first.
- swap_req  input  1  single-cycle pulse requesting a back/front swap at the next frame end.
- R1  output  1  serial pixel data to the board.
- A  output  1  row address to the board.
- clk  output  1  shift clock to the board; the board samples R1 on its rising edge.
- lat  output  1  latch strobe to the board, active-high.
- frame_done  output  1  one-cycle pulse in the last cycle of each frame.

## Operation
- Storage: two buffers (front and back), each 2×COLS bits. Writes always go to the back buffer. The display always reads from the front buffer.
- FSM states: SHIFT, LATCH, HOLD (HOLD exists only with ROW_HOLD_EN). The sequence is SHIFT → LATCH → [HOLD] → SHIFT with the row toggled.
- SHIFT:
  - On entry, load front[row] into the shift register.
  - For each of the COLS bits, MSB first: drive R1 = bit and clk = 0 for CLK_DIV cycles, then clk = 1 for CLK_DIV cycles.
  - After the last bit, clk returns to 0. R1 holds the last bit value.
- LATCH:
  - On entry, A = current row.
  - lat = 1 for CLK_DIV cycles.
  - clk stays 0.
- Row order is 0, 1, 0, 1, … and runs continuously. A frame is row 0 followed by row 1.
- Frame end is the last cycle of row 1's LATCH (or HOLD, when enabled). In that cycle:
  - frame_done = 1.
  - If a swap is pending, front and back exchange roles on the next edge, and pending clears.
- swap_req behaviour:
  - swap_req sets pending.
  - A swap_req arriving while already pending has no additional effect.
  - A swap_req arriving in the frame-end cycle takes effect at that same frame end.
- Write in the frame-end cycle when a swap occurs: the data lands in the pre-swap back buffer, so it becomes visible in the new frame.
- Write while wr_en = 1 and rstin = 1: ignored.
- Writing the back row that is currently being shifted has no visual effect; the front buffer is untouched.

## Timing
- Reset values:
  - R1 = 0, A = 0, clk = 0, lat = 0, frame_done = 0.
  - Both buffers all-zero; pending = 0.
  - State = SHIFT, row 0, bit counter = COLS-1, phase counter = 0.
- First cycle after rstin deasserts: the first clk-low phase of row 0 bit COLS-1.
- Row period is 2·CLK_DIV·COLS + CLK_DIV cycles, plus HOLD_CYCLES with ROW_HOLD_EN. There are no idle cycles between rows.
- R1 changes only at the start of a clk-low phase. This gives ≥ CLK_DIV cycles of setup and hold around each rising clk.
- A changes only on the first LATCH cycle.
- lat is never high while clk is high.
- A write is visible in the back buffer on the next edge. It reaches the display at the first frame end after a pending swap.
- Reset asserted mid-row: all outputs return to reset values on the next edge. No partial latch occurs after reset.

## Configuration
- ROW_HOLD_EN defined:
  - HOLD state added after LATCH.
  - During HOLD: lat = 0, clk = 0, A held, for HOLD_CYCLES cycles.
  - frame_done moves to the last HOLD cycle of row 1.
- ROW_HOLD_EN undefined:
  - No HOLD state; HOLD_CYCLES is ignored.
  - LATCH is followed directly by SHIFT of the next row.

## Test plan
- Reset behaviour: COLS=32, CLK_DIV=2, rstin high 3 cycles, then released → all outputs 0 during reset; first clk rising edge at cycle 2 after release; 32 rising edges per row; lat high exactly 2 cycles at cycle offset 128–129 with A=0.
- Swap visibility: write row0=32'hA5A5_0001, row1=32'h8000_0000, pulse swap_req → after the first frame_done, row 0 shifts out 1010_0101… ending in 1 and row 1 shifts out 1 then 31 zeros; the frame before the swap shifts all zeros.
- Duplicate and edge-case swap requests:
  - Two swap_req pulses within one frame produce exactly one swap.
  - swap_req in the frame-end cycle swaps at that same boundary.
- Write/swap collision: wr_en with wr_row=1, data 32'hFFFF_FFFF, issued in the swapping frame-end cycle → next frame row 1 shifts 32 ones.
- Mid-row reset: rstin asserted at bit 10 of row 1 → next cycle R1=A=clk=lat=0, no lat pulse follows; the scan restarts at row 0 with buffers cleared.
- ROW_HOLD_EN with HOLD_CYCLES=5, CLK_DIV=1, COLS=4: row period 14 cycles, frame_done every 28 cycles, clk and lat low throughout HOLD.

Source files
------------

// File: rtl/led_panel_driver.sv
// rtl/led_panel_driver.sv - free-running shift/latch/address scan driver with double-buffered 2-row store
// Optional post-latch dwell state enabled by defining ROW_HOLD_EN.
module led_panel_driver #(
   parameter int COLS        = 32,
   parameter int CLK_DIV     = 2,
   parameter int HOLD_CYCLES = 64
) (
   input  logic            clkin,
   input  logic            rstin,
   input  logic            wr_en,
   input  logic            wr_row,
   input  logic [COLS-1:0] wr_data,
   input  logic            swap_req,
   output logic            R1,
   output logic            A,
   output logic            clk,
   output logic            lat,
   output logic            frame_done
);

   localparam int BW      = $clog2(COLS);
   localparam int CNT_MAX = (HOLD_CYCLES > 2*CLK_DIV) ? HOLD_CYCLES : 2*CLK_DIV;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] SH_HIGH = CW'(CLK_DIV);
   localparam logic [CW-1:0] SH_LAST = CW'(2*CLK_DIV - 1);
   localparam logic [CW-1:0] LT_LAST = CW'(CLK_DIV - 1);
`ifdef ROW_HOLD_EN
   localparam logic [CW-1:0] HD_LAST = CW'(HOLD_CYCLES - 1);
`endif
   localparam logic [BW-1:0] BIT_TOP = BW'(COLS - 1);

`ifdef ROW_HOLD_EN
   typedef enum logic [1:0] {S_SHIFT, S_LATCH, S_HOLD} state_t;
`else
   typedef enum logic [1:0] {S_SHIFT, S_LATCH} state_t;
`endif

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [BW-1:0]   r_bit, w_bit_nxt;
   logic            r_row, w_row_nxt;
   logic            w_row_end;
   logic            w_frame_end;
   logic [COLS-1:0] r_buf [2][2];
   logic            r_sel;
   logic            r_pend;
   logic            r_clk, r_lat, r_a;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_bit_nxt   = r_bit;
      w_row_nxt   = r_row;
      w_row_end   = 1'b0;
      case (r_state)
         S_SHIFT: begin
            if (r_cnt == SH_LAST) begin
               w_cnt_nxt = '0;
               if (r_bit == '0) w_state_nxt = S_LATCH;
               else             w_bit_nxt   = r_bit - BW'(1);
            end
         end
         S_LATCH: begin
            if (r_cnt == LT_LAST) begin
               w_cnt_nxt = '0;
`ifdef ROW_HOLD_EN
               w_state_nxt = S_HOLD;
`else
               w_state_nxt = S_SHIFT;
               w_row_nxt   = ~r_row;
               w_bit_nxt   = BIT_TOP;
               w_row_end   = 1'b1;
`endif
            end
         end
`ifdef ROW_HOLD_EN
         S_HOLD: begin
            if (r_cnt == HD_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_SHIFT;
               w_row_nxt   = ~r_row;
               w_bit_nxt   = BIT_TOP;
               w_row_end   = 1'b1;
            end
         end
`endif
         default: w_state_nxt = S_SHIFT;
      endcase
   end

   assign w_frame_end = w_row_end & r_row;

   always_ff @(posedge clkin) begin
      if (rstin) begin
         r_state <= S_SHIFT;
         r_cnt   <= '0;
         r_bit   <= BIT_TOP;
         r_row   <= 1'b0;
         r_sel   <= 1'b0;
         r_pend  <= 1'b0;
         r_clk   <= 1'b0;
         r_lat   <= 1'b0;
         r_a     <= 1'b0;
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
               r_buf[i][j] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_row   <= w_row_nxt;
         // Board pins are registered from the next-state decode so they never glitch.
         r_clk   <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt >= SH_HIGH);
         r_lat   <= (w_state_nxt == S_LATCH);
         if (w_state_nxt == S_LATCH) r_a <= w_row_nxt;
         if (wr_en) r_buf[~r_sel][wr_row] <= wr_data;
         if (w_frame_end) begin
            if (r_pend | swap_req) r_sel <= ~r_sel;
            r_pend <= 1'b0;
         end else if (swap_req) begin
            r_pend <= 1'b1;
         end
      end
   end

   assign R1         = r_buf[r_sel][r_row][r_bit];
   assign A          = r_a;
   assign clk        = r_clk;
   assign lat        = r_lat;
   assign frame_done = w_frame_end;

endmodule
